// File: rtl/mydesign_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : mydesign_seq_ctrl
// Multi-cycle F = (((A >> i) + (B << j)) mod 2^N) * C with valid/ready I/O.
// Rev    : 1.0  initial release
// ============================================================================
module mydesign_seq_ctrl #(
  parameter int N  = 8,
  parameter int SW = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     A,
  input  logic [N-1:0]     B,
  input  logic [N-1:0]     C,
  input  logic [SW-1:0]    i,
  input  logic [SW-1:0]    j,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   F,
  output logic             busy
);

  localparam int            CW         = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] C_CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    a_q, a_d, b_q, b_d, c_q, c_d, e_q, e_d;
  logic [SW-1:0]   sh_i_q, sh_i_d, sh_j_q, sh_j_d;
  logic [2*N-1:0]  acc_q, acc_d, f_q, f_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*N-1:0]  pp;
  logic [2*N-1:0]  acc_sum;

  // Partial product for the current multiplier bit; 2N bits so the sum never overflows.
  assign pp      = {{N{1'b0}}, e_q} << cnt_q;
  assign acc_sum = acc_q + (c_q[cnt_q] ? pp : '0);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    sh_i_d  = sh_i_q;
    sh_j_d  = sh_j_q;
    e_d     = e_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    f_d     = f_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          c_d     = C;
          sh_i_d  = i;
          sh_j_d  = j;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        // Both terms and the sum stay N bits wide: B overflow and carry-out drop.
        e_d     = (a_q >> sh_i_q) + (b_q << sh_j_q);
        acc_d   = '0;
        cnt_d   = '0;
        state_d = ST_MUL;
      end
      ST_MUL: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == C_CNT_LAST) begin
          f_d     = acc_sum;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      sh_i_q  <= '0;
      sh_j_q  <= '0;
      e_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      f_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      sh_i_q  <= sh_i_d;
      sh_j_q  <= sh_j_d;
      e_q     <= e_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      f_q     <= f_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign F         = f_q;

endmodule
`default_nettype wire

// File: tb/tb_mydesign_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_mydesign_seq_ctrl
// Directed scoreboard bench for mydesign_seq_ctrl (N=8, SW=3).
// Rev    : 1.0  initial release
// ============================================================================
module tb_mydesign_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  A, B, C;
  logic [2:0]  i, j;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] F;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [15:0] sb[$];

  mydesign_seq_ctrl #(.N(8), .SW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .C         (C),
    .i         (i),
    .j         (j),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .F         (F),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_e(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] ii, input logic [2:0] jj);
    logic [7:0] bs;
    logic [7:0] s;
    bs = b << jj;
    s  = (a >> ii) + bs;
    return s;
  endfunction

  // Presents operands, waits for the accept edge, pushes expected F, checks E.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                      input logic [2:0] ii, input logic [2:0] jj,
                      input logic [7:0] exp_e, input logic [15:0] exp_f,
                      input bit keep, output int acc_cyc);
    bit got;
    A = a; B = b; C = c; i = ii; j = jj;
    in_valid = 1'b1;
    got = 1'b0;
    acc_cyc = 0;
    for (int k = 0; k < 40; k++) begin
      if (in_ready) begin
        tick();
        acc_cyc = cyc;
        got = 1'b1;
        break;
      end
      tick();
    end
    check("accepted", {31'd0, got}, 32'd1);
    sb.push_back(exp_f);
    // Scramble inputs after the accept edge: the DUT must use latched copies.
    A = ~a; B = ~b; C = ~c; i = ~ii; j = ~jj;
    in_valid = keep;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    check("in_ready_after_accept", {31'd0, in_ready}, 32'd0);
    tick();
    check("e_reg", {24'd0, dut.e_q}, {24'd0, exp_e});
  endtask

  task automatic collect(input int acc_cyc, input int stall, input bit keep_ready);
    bit          got;
    logic [15:0] exp;
    got = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (out_valid) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check("out_valid_seen", {31'd0, got}, 32'd1);
    if (!got) return;
    check("latency", cyc - acc_cyc, 32'd9);
    check("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
    exp = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
    check("F", {16'd0, F}, {16'd0, exp});
    for (int k = 0; k < stall; k++) begin
      out_ready = 1'b0;
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_F", {16'd0, F}, {16'd0, exp});
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("exit_out_valid", {31'd0, out_valid}, 32'd0);
    check("exit_in_ready", {31'd0, in_ready}, 32'd1);
    check("F_held_in_idle", {16'd0, F}, {16'd0, exp});
    if (!keep_ready) out_ready = 1'b0;
  endtask

  initial begin
    int          acc1, acc2;
    logic [15:0] dropped;
    logic [7:0]  ra, rb, rc, re;
    logic [2:0]  ri, rj;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; C = '0; i = '0; j = '0;
    tick();
    tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_F", {16'd0, F}, 32'd0);
    rst = 1'b0;
    tick();

    // Basic vector
    send(8'h80, 8'h03, 8'h05, 3'd3, 3'd2, 8'h1C, 16'h008C, 1'b0, acc1);
    collect(acc1, 0, 1'b0);
    // E wrap: B term truncates to 0x80, sum carry dropped
    send(8'hFF, 8'hFF, 8'hFF, 3'd0, 3'd7, 8'h7F, 16'h7E81, 1'b0, acc1);
    collect(acc1, 0, 1'b0);
    // Maximum product, then zero multiplier
    send(8'hFF, 8'h00, 8'hFF, 3'd0, 3'd0, 8'hFF, 16'hFE01, 1'b0, acc1);
    collect(acc1, 0, 1'b0);
    send(8'hFF, 8'h00, 8'h00, 3'd0, 3'd0, 8'hFF, 16'h0000, 1'b0, acc1);
    collect(acc1, 0, 1'b0);

    // Backpressure with ignored in_valid pulses while busy
    send(8'h40, 8'h01, 8'h0A, 3'd1, 3'd1, 8'h22, 16'h0154, 1'b0, acc1);
    A = 8'hAA; B = 8'h55; C = 8'h77; i = 3'd5; j = 3'd6;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      tick();
      check("busy_ignores_in_valid", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    collect(acc1, 5, 1'b0);
    send(8'h10, 8'h10, 8'h03, 3'd4, 3'd0, 8'h11, 16'h0033, 1'b0, acc1);
    collect(acc1, 0, 1'b0);

    // Reset in the middle of MUL (cnt = 4)
    send(8'h80, 8'h03, 8'h05, 3'd3, 3'd2, 8'h1C, 16'h008C, 1'b0, acc1);
    dropped = sb.pop_front();
    tick(); tick(); tick(); tick();
    check("mid_cnt_before_rst", {29'd0, dut.cnt_q}, 32'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_F", {16'd0, F}, 32'd0);
    send(8'h80, 8'h03, 8'h05, 3'd3, 3'd2, 8'h1C, 16'h008C, 1'b0, acc1);
    collect(acc1, 0, 1'b0);

    // Back-to-back: out_ready tied high, in_valid held across two operand sets
    out_ready = 1'b1;
    send(8'h80, 8'h03, 8'h05, 3'd3, 3'd2, 8'h1C, 16'h008C, 1'b1, acc1);
    A = 8'hFF; B = 8'hFF; C = 8'hFF; i = 3'd0; j = 3'd7;
    collect(acc1, 0, 1'b1);
    send(8'hFF, 8'hFF, 8'hFF, 3'd0, 3'd7, 8'h7F, 16'h7E81, 1'b0, acc2);
    check("b2b_accept_spacing", acc2 - acc1, 32'd11);
    collect(acc2, 0, 1'b0);

    // A few random operand sets against the reference model
    for (int n = 0; n < 4; n++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom);
      ri = 3'($urandom_range(0, 7)); rj = 3'($urandom_range(0, 7));
      re = model_e(ra, rb, ri, rj);
      send(ra, rb, rc, ri, rj, re, 16'(re) * 16'(rc), 1'b0, acc1);
      collect(acc1, n, 1'b0);
    end

    check("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
